sample_clock_divider: RTL and testbench

- Free-running clock divider that turns the 10 MHz system clock into a one-cycle sample strobe at ~44.05 kHz (10 MHz / 227).
- Sits at the front of the audio path and paces sample generation and output for the synthesizer datapath.
- No enable or clear inputs; it counts continuously whenever reset is deasserted.

---
 rtl/sample_clock_divider_pkg.sv | 7 +
 rtl/sample_clock_divider_counter.sv | 32 +++
 rtl/sample_clock_divider.sv | 23 ++
 tb/tb_sample_clock_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sample_clock_divider_pkg.sv
// Shared audio-path constants: sample-rate divider settings for the 10 MHz system clock.
package sample_clock_divider_pkg;

  localparam int unsigned SAMPLE_DIVISOR   = 227;
  localparam int unsigned SAMPLE_CNT_WIDTH = 8;

endpackage

// File: rtl/sample_clock_divider_counter.sv
// Generic free-running mod-N counter; at_max_o flags the terminal count N-1.
module sample_clock_divider_counter #(
  parameter int unsigned N     = 227,
  parameter int unsigned Width = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic at_max_o
);

  localparam logic [Width-1:0] MaxCount = Width'(N - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q == MaxCount) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == MaxCount);

endmodule

// File: rtl/sample_clock_divider.sv
// Sample strobe generator: one-cycle pulse on samp_enable every DIVISOR MHz10 cycles.
module sample_clock_divider
  import sample_clock_divider_pkg::*;
#(
  parameter int unsigned DIVISOR   = SAMPLE_DIVISOR,
  parameter int unsigned CNT_WIDTH = SAMPLE_CNT_WIDTH
) (
  input  logic MHz10,
  input  logic rst,
  output logic samp_enable
);

  // Strobe is a direct decode of the registered count, so reset drops it asynchronously.
  sample_clock_divider_counter #(
    .N     (DIVISOR),
    .Width (CNT_WIDTH)
  ) u_counter (
    .clk_i    (MHz10),
    .rst_i    (rst),
    .at_max_o (samp_enable)
  );

endmodule

// File: tb/tb_sample_clock_divider.sv
// Bench for sample_clock_divider: default and DIVISOR=4 instances vs. an edge-counting model.
module tb_sample_clock_divider;

  localparam int unsigned D0 = 227;
  localparam int unsigned D1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic se0, se1;

  int n_tests = 0;
  int n_fail  = 0;

  // Rising edges seen since reset was last released.
  int unsigned edges = 0;

  sample_clock_divider dut0 (
    .MHz10       (clk),
    .rst         (rst),
    .samp_enable (se0)
  );

  sample_clock_divider #(
    .DIVISOR   (D1),
    .CNT_WIDTH (2)
  ) dut1 (
    .MHz10       (clk),
    .rst         (rst),
    .samp_enable (se1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic logic model_se(logic r, int unsigned n, int unsigned d);
    return !r && ((n % d) == d - 1);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_d227", se0, model_se(rst, edges, D0));
    check("model_d4", se1, model_se(rst, edges, D1));
  end

  task automatic release_at_negedge();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Assumes rst was just released between edges; checks full first-strobe latency.
  task automatic first_strobe(input string tag);
    logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check({tag, "_d4_pattern"}, se1, pat[i]);
    end
    repeat (217) @(posedge clk);
    #1 check({tag, "_edge225"}, se0, 1'b0);
    @(posedge clk);
    #1 check({tag, "_edge226"}, se0, 1'b1);
    @(posedge clk);
    #1 check({tag, "_edge227"}, se0, 1'b0);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int gap_bad;
    int dbl;
    logic prev;
    bit found;

    // Power-on reset.
    #1 rst = 1'b1;
    #1 check("reset_async_d227", se0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_hold_d227", se0, 1'b0);
      check("reset_hold_d4", se1, 1'b0);
    end
    release_at_negedge();
    @(posedge clk);
    #1 check("post_release_d227", se0, 1'b0);
    check("post_release_d4", se1, 1'b0);

    // First strobe from a clean reset.
    rst = 1'b1;
    release_at_negedge();
    first_strobe("first");

    // Periodicity: edges 228..1362 must hold pulses at 453, 680, 907, 1134, 1361.
    pulses = 0; last_pulse = 226; gap_bad = 0; dbl = 0; prev = 1'b0;
    for (int e = 228; e <= 1362; e++) begin
      @(posedge clk);
      #1;
      if (se0) begin
        pulses++;
        if (e - last_pulse != int'(D0)) gap_bad++;
        last_pulse = e;
        if (prev) dbl++;
      end
      prev = se0;
    end
    n_tests++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL period_count: got %0d pulses, expected 5", pulses);
    end
    n_tests++;
    if (gap_bad != 0 || dbl != 0) begin
      n_fail++;
      $display("FAIL period_spacing: got %0d bad gaps %0d doubles, expected 0 0", gap_bad, dbl);
    end

    // Async reset mid-count (count 100), then full latency again.
    rst = 1'b1;
    release_at_negedge();
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midcount_rst_d227", se0, 1'b0);
    release_at_negedge();
    first_strobe("midcount");

    // Reset while the strobe is high must drop it before the next edge.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #1 found = se0;
    end
    check("strobe_seen", found, 1'b1);
    #1 rst = 1'b1;
    #1 check("strobe_rst_drop", se0, 1'b0);
    release_at_negedge();
    first_strobe("after_strobe_rst");

    // Randomized reset assertions at random phases and durations.
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 700)) @(posedge clk);
      #($urandom_range(1, 4)) rst = 1'b1;
      #1 check("rand_rst_d227", se0, 1'b0);
      check("rand_rst_d4", se1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #($urandom_range(1, 4)) rst = 1'b0;
    end
    repeat (500) @(posedge clk);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
